// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO: 8N1-style framing, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          ser_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
  logic par_q;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  state_t              state, state_nxt;
  logic [BW-1:0]       baud_cnt, baud_nxt;
  logic [NW-1:0]       bit_cnt, bit_nxt;
  logic                stop_cnt, stop_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                ser_nxt, done_nxt;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_nxt;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic                push, pop, baud_last, stop_last;

  // empty/full are registered, so a fresh write is only visible to the FSM one edge later
  assign push      = wr_en && !full;
  assign pop       = (state == IDLE) && !empty;
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);
  assign baud_last = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign stop_last = stop_cnt == 1'(STOP_BITS - 1);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    shreg_nxt = shreg;
    ser_nxt   = ser_out;
    done_nxt  = 1'b0;
    if (state != IDLE) baud_nxt = baud_last ? '0 : baud_cnt + BW'(1);
    case (state)
      IDLE: begin
        ser_nxt  = 1'b1;
        baud_nxt = '0;
        if (pop) begin
          state_nxt = START;
          shreg_nxt = mem[rd_ptr];
          ser_nxt   = 1'b0;
        end
      end
      START: if (baud_last) begin
        state_nxt = DATA;
        bit_nxt   = '0;
        ser_nxt   = shreg[0];
      end
      DATA: if (baud_last) begin
        if (bit_cnt == NW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
          ser_nxt   = par_q;
`else
          state_nxt = STOP;
          ser_nxt   = 1'b1;
          stop_nxt  = 1'b0;
`endif
        end else begin
          bit_nxt   = bit_cnt + NW'(1);
          shreg_nxt = shreg >> 1;
          ser_nxt   = shreg[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) begin
        state_nxt = STOP;
        ser_nxt   = 1'b1;
        stop_nxt  = 1'b0;
      end
`endif
      STOP: begin
        // registered pulse lands on the final cycle of the last stop bit
        if (stop_last && baud_cnt == BW'(CLKS_PER_BIT - 2)) done_nxt = 1'b1;
        if (baud_last) begin
          if (stop_last) begin
            state_nxt = IDLE;
            ser_nxt   = 1'b1;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      ser_out    <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      stop_cnt   <= stop_nxt;
      shreg      <= shreg_nxt;
      ser_out    <= ser_nxt;
      busy       <= state_nxt != IDLE;
      tx_done    <= done_nxt;
      overflow   <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nxt;
      empty      <= count_nxt == '0;
      full       <= count_nxt == CW'(FIFO_DEPTH);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   par_q <= 1'b0;
    else if (pop) par_q <= ^mem[rd_ptr];
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + random bench for uart_tx_fifo against a queue/countdown line model.
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PAR = 1;
`else
  localparam int SB = 1;
  localparam int PAR = 0;
`endif
  localparam int FRAME_CYC = CPB * (1 + DW + PAR + SB);

  logic clk, reset, wr_en;
  logic [DW-1:0] wr_data;
  logic full, empty, overflow, busy, tx_done, ser_out;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .fifo_count(fifo_count), .overflow(overflow), .busy(busy), .tx_done(tx_done), .ser_out(ser_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q[$];
  int rem = 0;
  logic [DW-1:0] cur = '0;
  int cyc = 0;
  int done_cyc[$];
  int ovf_cnt = 0;
  bit pop_full = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected line level from position inside the current frame
  function automatic logic exp_line();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME_CYC - rem) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return cur[idx-1];
    if (PAR == 1 && idx == DW + 1) return ^cur;
    return 1'b1;
  endfunction

  task automatic step(input logic w, input logic [DW-1:0] d);
    int pre;
    bit pop, push, ovf;
    wr_en = w;
    wr_data = d;
    @(posedge clk);
    pre = q.size();
    pop = (rem == 0) && (pre > 0);
    push = w && (pre < DEPTH);
    ovf = w && (pre == DEPTH);
    pop_full = pop && ovf;
    if (rem > 0) rem--;
    else if (pop) begin
      cur = DW'(q.pop_front());
      rem = FRAME_CYC;
    end
    if (push) q.push_back(int'(d));
    cyc++;
    #1;
    if (tx_done === 1'b1) done_cyc.push_back(cyc);
    if (overflow === 1'b1) ovf_cnt++;
    chk("ser_out", ser_out, exp_line());
    chk("busy", busy, rem > 0);
    chk("tx_done", tx_done, rem == 1);
    chk("overflow", overflow, ovf);
    chk("fifo_count", fifo_count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_ser_out", ser_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    q.delete();
    rem = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    #1;
    do_reset();
    idle(3);

    // single frame 0xA5
    done_cyc.delete();
    step(1'b1, 8'hA5);
    idle(FRAME_CYC + 5);
    chk("single_done_cnt", done_cyc.size(), 1);

    // back-to-back 0x00, 0xFF
    done_cyc.delete();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    idle(2 * FRAME_CYC + 6);
    chk("b2b_done_cnt", done_cyc.size(), 2);
    chk("b2b_done_gap", done_cyc[1] - done_cyc[0], FRAME_CYC + 1);

    // 5-write burst from reset: all accepted, 5 frames
    do_reset();
    done_cyc.delete();
    ovf_cnt = 0;
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i));
    idle(5 * (FRAME_CYC + 1) + 5);
    chk("burst5_done_cnt", done_cyc.size(), 5);
    chk("burst5_ovf_cnt", ovf_cnt, 0);

    // 6-write burst: last write dropped
    do_reset();
    ovf_cnt = 0;
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i));
    chk("burst6_overflow", overflow, 1);
    chk("burst6_full", full, 1);
    chk("burst6_count", fifo_count, 4);
    chk("burst6_ovf_cnt", ovf_cnt, 1);

    // hold writes while full until the next pop happens on a full FIFO
    for (int i = 0; i < FRAME_CYC + 20; i++) begin
      step(1'b1, DW'($urandom));
      if (pop_full) begin
        chk("simul_overflow", overflow, 1);
        chk("simul_count", fifo_count, 3);
      end
    end
    idle(5 * (FRAME_CYC + 1) + 5);

    // reset at cycle 15 of a frame of zeros
    do_reset();
    step(1'b1, 8'h00);
    step(1'b0, '0);
    repeat (15) step(1'b0, '0);
    chk("mid_line_low", ser_out, 0);
    done_cyc.delete();
    do_reset();
    idle(FRAME_CYC + 5);
    chk("mid_no_done", done_cyc.size(), 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) step($urandom_range(0, 4) == 0, DW'($urandom));
    idle(5 * (FRAME_CYC + 1) + 10);
    chk("rand_drained", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
